attn_dot_sequencer: RTL and testbench
=====================================

Name: attn_dot_sequencer

Overview:
Sequences the shared radix-4 Booth multiplier (mac_booth_fixed_unsigned) over one attention-score dot product (Q·K) per job. Protocol per job:
- Accepts a job length on a job handshake.
- Pulls LEN unsigned element pairs through a valid/ready stream.
- Issues one single-cycle start per pair and waits for mac_done.
- Accumulates products in a wide register and presents the sum on a result valid/ready port.

Sits between the Q/K operand buffers and the softmax stage.

Parameters:
MUL_W, 24, operand width; must be even; passed to the multiplier as mul_len.
PROD_W, 48, product width, 2*MUL_W; passed as out_len.
MAX_LEN, 16, maximum elements per job.
LEN_W, 5, job_len width, clog2(MAX_LEN+1).
ACC_W, 52, accumulator width; PROD_W+clog2(MAX_LEN) gives no overflow.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
job_valid  in  1  job request
job_ready  out  1  high only in IDLE
job_len  in  LEN_W  element count, 0..MAX_LEN
elem_valid  in  1  element pair valid
elem_ready  out  1  high only in FETCH
elem_a  in  MUL_W  Q element, unsigned
elem_b  in  MUL_W  K element, unsigned
res_valid  out  1  result valid, high only in DONE
res_ready  in  1  result consumer ready
res_data  out  ACC_W  dot-product sum
res_ovf  out  1  sticky accumulator carry-out for this job
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - acc, cnt, len_r, latched operands and res_ovf are cleared; all handshake outputs are 0.
  - The internal multiplier is reset on the same rst.
  - Reset mid-job abandons the job silently; no result is produced.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE: job_ready=1. On job_valid&job_ready: latch len_r=job_len, clear acc/cnt/res_ovf. Next state is FETCH, or DONE if job_len==0.
- FETCH: elem_ready=1. On elem_valid: latch elem_a/elem_b and go to ISSUE. Without elem_valid, stay in FETCH with no timeout.
- ISSUE:
  - mul_start=1 for exactly one cycle, with the latched operands on the multiplier a/b.
  - Go to WAIT. mul_start is never high in any other state.
- WAIT:
  - On mul_done: acc <= acc + zero-extend(product); res_ovf |= carry-out of that add; cnt++.
  - If cnt==len_r-1, go to DONE; else go to FETCH.
- mul_done is ignored outside WAIT. The multiplier free-runs one spurious pass after reset and emits a done pulse ~DIGITS cycles later; that pulse must not affect acc.
- DONE: res_valid=1; res_data=acc; res_ovf valid. Hold until res_ready, then go to IDLE. res_data stays stable while res_valid is high.
- Timing:
  - DIGITS = MUL_W/2+1 (13 at default).
  - mul_done is visible DIGITS cycles after the edge that samples mul_start.
  - Per element with elem_valid always high: FETCH 1 + ISSUE 1 + WAIT DIGITS+1 = DIGITS+3 cycles (16 at default).
  - res_valid rises len*(DIGITS+3) cycles after the job-accept edge; 1 cycle after for len=0.
- Width rules:
  - Products are zero-extended to ACC_W; the sum wraps modulo 2^ACC_W.
  - job_len > MAX_LEN is out of contract; the block still counts to len_r, and no assertion is required in RTL.
- Simultaneous events:
  - A job arriving in DONE waits, since job_ready=0.
  - res_ready held high in DONE gives a 1-cycle DONE; a new job can be accepted on the following IDLE cycle.
  - Throughput is one job at a time; there is no overlap.

Decomposition:
- Package attn_sched_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE, FETCH, ISSUE, WAIT, DONE};
  - function booth_digits(mul_w) returning mul_w/2+1;
  - localparam defaults for MUL_W/PROD_W.
- One sub-module instance: mac_booth_fixed_unsigned (u_mul), with mul_len=MUL_W and out_len=PROD_W.
- The FSM, counter and accumulator stay in this module.

Test Plan:
1. len=3, pairs (3,5),(7,11),(1,1), elem_valid/res_ready always high -> res_data=93, res_ovf=0, res_valid exactly 48 cycles after job accept, mul_start pulsed 3 times, each 1 cycle wide.
2. len=16, all pairs (0xFFFFFF,0xFFFFFF) -> res_data=16*0xFFFFFE000001=0xFFFFFE0000010, res_ovf=0. With ACC_W=48 override: wrapped value 0xFFFFE0000010 and res_ovf=1.
3. len=0 -> res_valid one cycle after accept, res_data=0, elem_ready never asserted, mul_start never asserted.
4. Backpressure: elem_valid low 5 cycles in FETCH before each pair; res_ready low 7 cycles in DONE -> correct sum, res_data stable while stalled, job_ready=0 throughout.
5. Post-reset spurious mul_done: deassert rst, then immediately issue a len=1 job (2,4) -> res_data=8; the spurious done pulse is not double-counted.
6. Assert rst during the WAIT of element 2 of a len=4 job, then run len=2 (10,10),(20,20) -> no result from the first job, second job gives 500.

Source files
------------

// File: rtl/attn_sched_pkg.sv
// Shared types and helpers for the attention dot-product scheduler.
package attn_sched_pkg;

    localparam int DEF_MUL_W  = 24;
    localparam int DEF_PROD_W = 2 * DEF_MUL_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } seq_state_t;

    // Radix-4 digits needed for an unsigned operand of mul_w bits.
    // One extra digit covers the zero sign bit.
    function automatic int booth_digits(input int mul_w);
        return mul_w / 2 + 1;
    endfunction

endpackage

// File: rtl/mac_booth_fixed_unsigned.sv
// Iterative radix-4 Booth multiplier for unsigned operands, one digit per cycle.
// Out of reset it runs one pass on zero operands and pulses done at the end.
// A start while busy restarts the multiplier with the new operands.
module mac_booth_fixed_unsigned
    import attn_sched_pkg::*;
#(
    parameter int mul_len = DEF_MUL_W,
    parameter int out_len = DEF_PROD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [mul_len-1:0] a_i,
    input  logic [mul_len-1:0] b_i,
    output logic [out_len-1:0] product_o,
    output logic               done_o
);

    localparam int DIGITS = booth_digits(mul_len);
    localparam int CNT_W  = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    // Booth recoding of one digit; arithmetic wraps modulo 2^out_len, which
    // still gives the exact product because a*b < 2^out_len.
    function automatic logic signed [out_len-1:0] booth_pp(
        input logic [2:0]                trip,
        input logic signed [out_len-1:0] m
    );
        case (trip)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m <<< 1;
            3'b100:         booth_pp = -(m <<< 1);
            3'b101, 3'b110: booth_pp = -m;
            default:        booth_pp = '0;
        endcase
    endfunction

    logic [mul_len+1:0]        mplr_q;
    logic                      prev_q;
    logic signed [out_len-1:0] mcand_q;
    logic signed [out_len-1:0] sum_q;
    logic signed [out_len-1:0] sum_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      busy_q;
    logic                      done_q;
    logic [out_len-1:0]        prod_q;

    // Partial-product add for the current digit.
    always_comb begin
        sum_d = sum_q + booth_pp({mplr_q[1:0], prev_q}, mcand_q);
    end

    // Load on start, then retire one Booth digit per cycle until the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mplr_q  <= '0;
            prev_q  <= 1'b0;
            mcand_q <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                mplr_q  <= {2'b00, b_i};
                prev_q  <= 1'b0;
                mcand_q <= signed'({{(out_len - mul_len){1'b0}}, a_i});
                sum_q   <= '0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                sum_q   <= sum_d;
                mcand_q <= mcand_q <<< 2;
                mplr_q  <= mplr_q >> 2;
                prev_q  <= mplr_q[1];
                cnt_q   <= cnt_q + 1'b1;
                if (cnt_q == LAST_DIGIT) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    prod_q <= unsigned'(sum_d);
                end
            end
        end
    end

    assign product_o = prod_q;
    assign done_o    = done_q;

endmodule

// File: rtl/attn_dot_sequencer.sv
// Runs one Q.K dot product per job through the shared Booth multiplier,
// accumulating products and handing the sum to the softmax stage.
module attn_dot_sequencer
    import attn_sched_pkg::*;
#(
    parameter int MUL_W   = DEF_MUL_W,
    parameter int PROD_W  = DEF_PROD_W,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int ACC_W   = 52
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    input  logic             elem_valid,
    output logic             elem_ready,
    input  logic [MUL_W-1:0] elem_a,
    input  logic [MUL_W-1:0] elem_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    if (LEN_W < $clog2(MAX_LEN + 1) || ACC_W < PROD_W) begin : g_bad_cfg
        $error("attn_dot_sequencer: LEN_W or ACC_W too narrow");
    end

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    seq_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [MUL_W-1:0]  a_q, a_d;
    logic [MUL_W-1:0]  b_q, b_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic              mul_start;
    logic              mul_done;
    logic [PROD_W-1:0] mul_product;
    logic [ACC_W:0]    sum_wide;

    mac_booth_fixed_unsigned #(
        .mul_len (MUL_W),
        .out_len (PROD_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (a_q),
        .b_i       (b_q),
        .product_o (mul_product),
        .done_o    (mul_done)
    );

    // Accumulator add with carry-out kept for the sticky overflow flag.
    always_comb begin
        sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_product};
    end

    // Next-state and datapath updates; mul_done only counts while in WAIT.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    len_d   = job_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (job_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (elem_valid) begin
                    a_d     = elem_a;
                    b_d     = elem_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    acc_d   = sum_wide[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_wide[ACC_W];
                    cnt_d   = cnt_q + LEN_ONE;
                    state_d = (cnt_q == len_q - LEN_ONE) ? DONE : FETCH;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // job_ready is masked while reset is held so no handshake is offered.
    assign job_ready  = (state_q == IDLE) && !rst;
    assign elem_ready = (state_q == FETCH);
    assign res_valid  = (state_q == DONE);
    assign mul_start  = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign res_data   = acc_q;
    assign res_ovf    = ovf_q;

endmodule

// File: tb/tb_attn_dot_sequencer.sv
// Randomized bench for attn_dot_sequencer with a plain-arithmetic sum model.
module tb_attn_dot_sequencer;

    localparam int MUL_W   = 24;
    localparam int LEN_W   = 5;
    localparam int ACC_W   = 52;
    localparam int PER_EL  = MUL_W / 2 + 1 + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic             elem_valid;
    logic             elem_ready;
    logic [MUL_W-1:0] elem_a;
    logic [MUL_W-1:0] elem_b;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_ovf;
    logic             busy;

    attn_dot_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_len    (job_len),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_a     (elem_a),
        .elem_b     (elem_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   st_hi = 0;
    int   st_rise = 0;
    int   er_hi = 0;
    logic st_prev = 1'b0;

    logic [MUL_W-1:0] op_a [32];
    logic [MUL_W-1:0] op_b [32];
    int               gap  [32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut.mul_start) begin
            st_hi <= st_hi + 1;
            if (!st_prev) st_rise <= st_rise + 1;
        end
        st_prev <= dut.mul_start;
        if (elem_ready) er_hi <= er_hi + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full job: reference sum, accept, feed pairs, collect result.
    task automatic run_job(input int len, input int rgap);
        logic [63:0] es;
        logic [63:0] wrap;
        bit          eo;
        int          s_hi, s_rise, s_er, tgap, t0, n;
        es   = 64'd0;
        eo   = 1'b0;
        wrap = 64'd1 << ACC_W;
        for (int i = 0; i < len; i++) begin
            es = es + 64'(op_a[i]) * 64'(op_b[i]);
            if (es >= wrap) begin
                eo = 1'b1;
                es = es - wrap;
            end
        end
        s_hi = st_hi; s_rise = st_rise; s_er = er_hi; tgap = 0;

        n = 0;
        while (!job_ready && n < 100) begin tick(); n++; end
        chk("job_ready_idle", 64'(job_ready), 64'd1);
        job_valid = 1'b1;
        job_len   = LEN_W'(len);
        tick();
        t0 = cyc;
        job_valid = 1'b0;

        for (int i = 0; i < len; i++) begin
            n = 0;
            while (!elem_ready && n < 200) begin tick(); n++; end
            if (!elem_ready) begin
                chk("elem_ready_timeout", 64'd0, 64'd1);
                return;
            end
            for (int g = 0; g < gap[i]; g++) begin
                chk("job_ready_busy", 64'(job_ready), 64'd0);
                tick();
            end
            tgap += gap[i];
            elem_valid = 1'b1;
            elem_a = op_a[i];
            elem_b = op_b[i];
            tick();
            elem_valid = 1'b0;
        end

        n = 0;
        while (!res_valid && n < 200) begin tick(); n++; end
        if (!res_valid) begin
            chk("res_valid_timeout", 64'd0, 64'd1);
            return;
        end
        chk("latency", 64'(cyc - t0), 64'(len * PER_EL + tgap));
        chk("res_data", 64'(res_data), es);
        chk("res_ovf", 64'(res_ovf), 64'(eo));
        for (int g = 0; g < rgap; g++) begin
            tick();
            chk("res_hold", 64'(res_data), es);
            chk("res_valid_hold", 64'(res_valid), 64'd1);
            chk("job_ready_done", 64'(job_ready), 64'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_drop", 64'(res_valid), 64'd0);
        chk("job_ready_back", 64'(job_ready), 64'd1);
        chk("start_cycles", 64'(st_hi - s_hi), 64'(len));
        chk("start_pulses", 64'(st_rise - s_rise), 64'(len));
        chk("elem_ready_cycles", 64'(er_hi - s_er), 64'(len + tgap));
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 32; i++) gap[i] = 0;
    endtask

    initial begin
        int n;
        rst = 1'b1; job_valid = 1'b0; job_len = '0; elem_valid = 1'b0;
        elem_a = '0; elem_b = '0; res_ready = 1'b0;
        clear_gaps();
        repeat (3) tick();
        chk("rst_job_ready", 64'(job_ready), 64'd0);
        chk("rst_elem_ready", 64'(elem_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_ovf", 64'(res_ovf), 64'd0);

        // Job straight out of reset while the multiplier's spurious pass runs.
        rst = 1'b0;
        op_a[0] = 24'd2; op_b[0] = 24'd4;
        run_job(1, 0);

        // Small known vector: 15 + 77 + 1.
        op_a[0] = 24'd3; op_b[0] = 24'd5;
        op_a[1] = 24'd7; op_b[1] = 24'd11;
        op_a[2] = 24'd1; op_b[2] = 24'd1;
        run_job(3, 0);

        // Full-length job of maximum operands.
        for (int i = 0; i < 32; i++) begin op_a[i] = 24'hFFFFFF; op_b[i] = 24'hFFFFFF; end
        run_job(16, 0);
        // Over-length job wraps the accumulator and sets the sticky carry.
        run_job(20, 0);

        // Empty job.
        run_job(0, 0);

        // Backpressure on both sides.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = MUL_W'($urandom); op_b[i] = MUL_W'($urandom); gap[i] = 5;
        end
        run_job(4, 7);
        clear_gaps();

        // Reset during the second element's multiply abandons the job.
        job_valid = 1'b1; job_len = 5'd4;
        tick();
        job_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (!elem_ready && n < 100) begin tick(); n++; end
            elem_valid = 1'b1; elem_a = 24'd9; elem_b = 24'd9;
            tick();
            elem_valid = 1'b0;
        end
        repeat (5) tick();
        chk("mid_job_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_res_data", 64'(res_data), 64'd0);
        chk("mid_rst_job_ready", 64'(job_ready), 64'd0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (res_valid || busy) n++;
            tick();
        end
        chk("no_result_after_rst", 64'(n), 64'd0);
        op_a[0] = 24'd10; op_b[0] = 24'd10;
        op_a[1] = 24'd20; op_b[1] = 24'd20;
        run_job(2, 0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            int len;
            len = int'($urandom_range(16, 0));
            for (int i = 0; i < len; i++) begin
                op_a[i] = MUL_W'($urandom);
                op_b[i] = MUL_W'($urandom);
                gap[i]  = int'($urandom_range(2, 0));
            end
            run_job(len, int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
